// File: rtl/fclass_fcvt_s.sv
// fclass_fcvt_s
//
// Single-precision FPU sub-unit covering three RISC-V F-extension operations:
//   FCLASS.S  (operation = 8): 10-bit one-hot class mask of a binary32 operand
//   FCVT.S.W  (operation = 4): signed 32-bit integer   -> binary32
//   FCVT.S.WU (operation = 5): unsigned 32-bit integer -> binary32
// Any other operation code produces out = 0, nx = 0 with valid_out still set.
//
// Timing: fully pipelined, one-cycle latency, no backpressure. All decode,
// leading-one detection, normalisation and rounding happen combinationally
// ahead of a single output register.
//
// Ports:
//   clk        in   1   rising-edge clock
//   resetn     in   1   synchronous reset, active HIGH (despite the name)
//   valid_in   in   1   operation/operands valid this cycle
//   operation  in   6   operation code (4, 5, 8 supported)
//   rs1        in  32   integer source (conversions) or binary32 (FCLASS)
//   rs2        in  32   unused; present for a uniform FPU unit interface
//   rm         in   3   rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM,
//                       5..7 behave as RNE
//   valid_out  out  1   out/nx hold a fresh result this cycle
//   out        out 32   result (holds its value when valid_out = 0)
//   nx         out  1   inexact flag accompanying out

module fclass_fcvt_s (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid_in,
    input  logic [5:0]  operation,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [2:0]  rm,
    output logic        valid_out,
    output logic [31:0] out,
    output logic        nx
);

    localparam logic [5:0] OP_FCVT_S_W  = 6'd4;
    localparam logic [5:0] OP_FCVT_S_WU = 6'd5;
    localparam logic [5:0] OP_FCLASS_S  = 6'd8;

    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    // rs2 has no function here; the reduction only keeps lint quiet.
    logic w_unused_rs2;
    assign w_unused_rs2 = ^rs2;

    // ------------------------------------------------------------------
    // FCLASS.S
    // ------------------------------------------------------------------
    logic        w_s;
    logic [7:0]  w_e;
    logic [22:0] w_f;
    logic        w_e_max;
    logic        w_e_zero;
    logic        w_f_zero;
    logic [9:0]  w_class;

    assign w_s      = rs1[31];
    assign w_e      = rs1[30:23];
    assign w_f      = rs1[22:0];
    assign w_e_max  = &w_e;
    assign w_e_zero = ~|w_e;
    assign w_f_zero = ~|w_f;

    assign w_class[0] =  w_s & w_e_max  &  w_f_zero;
    assign w_class[1] =  w_s & ~w_e_max & ~w_e_zero;
    assign w_class[2] =  w_s & w_e_zero & ~w_f_zero;
    assign w_class[3] =  w_s & w_e_zero &  w_f_zero;
    assign w_class[4] = ~w_s & w_e_zero &  w_f_zero;
    assign w_class[5] = ~w_s & w_e_zero & ~w_f_zero;
    assign w_class[6] = ~w_s & ~w_e_max & ~w_e_zero;
    assign w_class[7] = ~w_s & w_e_max  &  w_f_zero;
    // NaN classes ignore the sign; f[22] separates quiet from signaling.
    assign w_class[8] = w_e_max & ~w_f_zero & ~w_f[22];
    assign w_class[9] = w_e_max & w_f[22];

    // ------------------------------------------------------------------
    // FCVT.S.W / FCVT.S.WU
    // ------------------------------------------------------------------
    logic        w_cvt_sign;
    logic [31:0] w_mag;
    logic [4:0]  w_lead_pos;
    logic [31:0] w_norm;
    logic [22:0] w_mant;
    logic        w_guard;
    logic        w_sticky;
    logic        w_cvt_nx;
    logic        w_round_inc;
    logic [23:0] w_mant_rnd;
    logic [7:0]  w_exp;
    logic [31:0] w_cvt_result;

    // Only the signed conversion interprets bit 31. Negating 0x80000000
    // yields 0x80000000, which read as unsigned is exactly 2^31.
    assign w_cvt_sign = (operation == OP_FCVT_S_W) & rs1[31];
    assign w_mag      = w_cvt_sign ? (~rs1 + 32'd1) : rs1;

    // Leading-one position; the highest set bit wins because it is
    // assigned last.
    always_comb begin
        w_lead_pos = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (w_mag[i]) begin
                w_lead_pos = i[4:0];
            end
        end
    end

    // Put the leading one at bit 31 (the hidden bit); the 23 bits below it
    // are the mantissa, then guard, then the sticky remainder.
    assign w_norm   = w_mag << (5'd31 - w_lead_pos);
    assign w_mant   = w_norm[30:8];
    assign w_guard  = w_norm[7];
    assign w_sticky = |w_norm[6:0];
    assign w_cvt_nx = w_guard | w_sticky;

    always_comb begin
        w_round_inc = w_guard & (w_sticky | w_mant[0]);  // RNE and 5..7
        case (rm)
            RM_RTZ:  w_round_inc = 1'b0;
            RM_RDN:  w_round_inc = w_cvt_sign & w_cvt_nx;
            RM_RUP:  w_round_inc = ~w_cvt_sign & w_cvt_nx;
            RM_RMM:  w_round_inc = w_guard;
            default: ;
        endcase
    end

    // A carry out of the mantissa leaves the mantissa at zero and bumps the
    // exponent; the largest possible result is 2^32, so no overflow exists.
    assign w_mant_rnd = {1'b0, w_mant} + {23'd0, w_round_inc};
    assign w_exp      = 8'd127 + {3'd0, w_lead_pos} + {7'd0, w_mant_rnd[23]};

    assign w_cvt_result = (w_mag == 32'd0) ? 32'd0
                                           : {w_cvt_sign, w_exp, w_mant_rnd[22:0]};

    // ------------------------------------------------------------------
    // Result select
    // ------------------------------------------------------------------
    logic [31:0] w_result;
    logic        w_nx;

    always_comb begin
        w_result = 32'd0;
        w_nx     = 1'b0;
        case (operation)
            OP_FCVT_S_W, OP_FCVT_S_WU: begin
                w_result = w_cvt_result;
                w_nx     = (w_mag != 32'd0) & w_cvt_nx;
            end
            OP_FCLASS_S: begin
                w_result = {22'd0, w_class};
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Output register: out/nx only update on an accepted operation.
    // ------------------------------------------------------------------
    logic        r_valid;
    logic [31:0] r_out;
    logic        r_nx;

    always_ff @(posedge clk) begin
        if (resetn) begin
            r_valid <= 1'b0;
            r_out   <= 32'd0;
            r_nx    <= 1'b0;
        end else begin
            r_valid <= valid_in;
            if (valid_in) begin
                r_out <= w_result;
                r_nx  <= w_nx;
            end
        end
    end

    assign valid_out = r_valid;
    assign out       = r_out;
    assign nx        = r_nx;

endmodule

// File: tb/tb_fclass_fcvt_s.sv
// Self-checking bench for fclass_fcvt_s. Expected {nx, out} values are
// pushed when an operation is driven and popped when valid_out appears.

module tb_fclass_fcvt_s;

    logic        clk;
    logic        resetn;
    logic        valid_in;
    logic [5:0]  operation;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  rm;
    logic        valid_out;
    logic [31:0] out;
    logic        nx;

    int checks   = 0;
    int failures = 0;

    logic [32:0] exp_q[$];

    fclass_fcvt_s dut (
        .clk       (clk),
        .resetn    (resetn),
        .valid_in  (valid_in),
        .operation (operation),
        .rs1       (rs1),
        .rs2       (rs2),
        .rm        (rm),
        .valid_out (valid_out),
        .out       (out),
        .nx        (nx)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [5:0] op, input logic [31:0] a,
                         input logic [2:0] mode, input logic [31:0] exp_out,
                         input logic exp_nx);
        @(posedge clk);
        #1;
        valid_in  = 1'b1;
        operation = op;
        rs1       = a;
        rs2       = $urandom;
        rm        = mode;
        exp_q.push_back({exp_nx, exp_out});
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        valid_in  = 1'b0;
        operation = 6'($urandom_range(0, 63));
        rs1       = $urandom;
        rs2       = $urandom;
        rm        = 3'($urandom_range(0, 7));
    endtask

    task automatic check(input string tag, input logic [32:0] obs,
                         input logic [32:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid_out", {1'b0, valid_out}, 33'd0);
            end else begin
                check("result", {nx, out}, exp_q.pop_front());
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        resetn    = 1'b1;
        valid_in  = 1'b0;
        operation = 6'd0;
        rs1       = 32'd0;
        rs2       = 32'd0;
        rm        = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {valid_out, nx, out}, 34'd0);
        resetn = 1'b0;

        // FCLASS sweep
        drive(6'd8, 32'hFF800000, 3'($urandom_range(0, 7)), 32'h001, 1'b0);
        drive(6'd8, 32'hBF800000, 3'($urandom_range(0, 7)), 32'h002, 1'b0);
        drive(6'd8, 32'h80000001, 3'($urandom_range(0, 7)), 32'h004, 1'b0);
        drive(6'd8, 32'h80000000, 3'($urandom_range(0, 7)), 32'h008, 1'b0);
        drive(6'd8, 32'h00000000, 3'($urandom_range(0, 7)), 32'h010, 1'b0);
        drive(6'd8, 32'h00000001, 3'($urandom_range(0, 7)), 32'h020, 1'b0);
        drive(6'd8, 32'h3F800000, 3'($urandom_range(0, 7)), 32'h040, 1'b0);
        drive(6'd8, 32'h7F800000, 3'($urandom_range(0, 7)), 32'h080, 1'b0);
        drive(6'd8, 32'h7F800001, 3'($urandom_range(0, 7)), 32'h100, 1'b0);
        drive(6'd8, 32'h7FC00000, 3'($urandom_range(0, 7)), 32'h200, 1'b0);
        drive(6'd8, 32'hFFC00000, 3'($urandom_range(0, 7)), 32'h200, 1'b0);

        // FCVT.S.W exact and boundary
        drive(6'd4, 32'h00000001, 3'd0, 32'h3F800000, 1'b0);
        drive(6'd4, 32'hFFFFFFFF, 3'd0, 32'hBF800000, 1'b0);
        drive(6'd4, 32'h00000000, 3'd0, 32'h00000000, 1'b0);
        drive(6'd4, 32'h80000000, 3'd0, 32'hCF000000, 1'b0);
        drive(6'd4, 32'h7FFFFFFF, 3'd0, 32'h4F000000, 1'b1);

        // Rounding on 2^24 + 1
        drive(6'd4, 32'h01000001, 3'd0, 32'h4B800000, 1'b1);
        drive(6'd4, 32'h01000001, 3'd1, 32'h4B800000, 1'b1);
        drive(6'd4, 32'h01000001, 3'd3, 32'h4B800001, 1'b1);
        drive(6'd4, 32'h01000001, 3'd4, 32'h4B800001, 1'b1);
        drive(6'd4, 32'h01000001, 3'd2, 32'h4B800000, 1'b1);
        drive(6'd4, 32'h01000001, 3'd5, 32'h4B800000, 1'b1);
        drive(6'd4, 32'hFEFFFFFF, 3'd2, 32'hCB800001, 1'b1);
        drive(6'd4, 32'hFEFFFFFF, 3'd3, 32'hCB800000, 1'b1);

        // FCVT.S.WU
        drive(6'd5, 32'hFFFFFFFF, 3'd0, 32'h4F800000, 1'b1);
        drive(6'd5, 32'hFFFFFFFF, 3'd1, 32'h4F7FFFFF, 1'b1);
        drive(6'd5, 32'h80000000, 3'd0, 32'h4F000000, 1'b0);

        // Back-to-back 8, 4, 5 then a gap: out must hold
        drive(6'd8, 32'h3F800000, 3'd0, 32'h040, 1'b0);
        drive(6'd4, 32'h00000001, 3'd0, 32'h3F800000, 1'b0);
        drive(6'd5, 32'h00000003, 3'd0, 32'h40400000, 1'b0);
        idle();
        @(posedge clk);
        #1;
        check("gap_hold", {valid_out, nx, out}, {1'b0, 1'b0, 32'h40400000});
        idle();
        @(posedge clk);
        #1;
        check("gap_hold2", {valid_out, nx, out}, {1'b0, 1'b0, 32'h40400000});

        // Unsupported operation
        drive(6'd9, 32'h12345678, 3'd0, 32'h00000000, 1'b0);
        drive(6'd4, 32'h7FFFFFFF, 3'd3, 32'h4F000000, 1'b1);
        drive(6'd63, 32'hFFFFFFFF, 3'd0, 32'h00000000, 1'b0);

        // Reset one cycle after issuing; valid_in during reset is ignored
        drive(6'd8, 32'h7F800000, 3'd0, 32'h080, 1'b0);
        @(posedge clk);
        #1;
        resetn    = 1'b1;
        valid_in  = 1'b1;
        operation = 6'd4;
        rs1       = 32'h7FFFFFFF;
        @(posedge clk);
        #1;
        check("reset_mid_stream", {valid_out, nx, out}, 34'd0);
        resetn   = 1'b0;
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        check("no_stale_after_reset", {valid_out, nx, out}, 34'd0);

        // Post-reset operation still works
        drive(6'd4, 32'h00000002, 3'd0, 32'h40000000, 1'b0);
        idle();

        // Bounded drain
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        @(negedge clk);
        check("queue_drained", 33'(exp_q.size()), 33'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fclass_fcvt_s.md
# fclass_fcvt_s

Single-precision FPU sub-unit for the RISC-V F-extension datapath. It implements three operations:
- FCLASS.S: 10-bit class mask of an IEEE-754 binary32 operand.
- FCVT.S.W: signed 32-bit integer to binary32.
- FCVT.S.WU: unsigned 32-bit integer to binary32.

It sits beside the other FPU operation units. The FPU top selects its result by operation code. The output is registered, with a one-cycle latency.

## Interface
- No parameters (FLEN fixed at 32).
- clk  input  1  clock; all state updates on rising edge.
- resetn  input  1  synchronous reset, active-high: asserted (1) at a rising edge clears all state.
- valid_in  input  1  operands/op valid this cycle.
- operation  input  6  4 = FCVT.S.W, 5 = FCVT.S.WU, 8 = FCLASS.S; any other value = unsupported.
- rs1  input  32  source operand: integer for conversions, binary32 for FCLASS.
- rs2  input  32  unused; present for a uniform FPU unit interface.
- rm  input  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101–111 treated as RNE.
- valid_out  output  1  result/flags valid.
- out  output  32  result.
- nx  output  1  inexact flag for the result in out.

## Operation
- FCLASS.S: out[9:0] one-hot, out[31:10] = 0. Classes are decoded from sign s, exponent e = rs1[30:23] and fraction f = rs1[22:0]:
  - bit0: −inf (s=1, e=FF, f=0).
  - bit1: −normal (s=1, e in 01..FE).
  - bit2: −subnormal (s=1, e=0, f≠0).
  - bit3: −0.
  - bit4: +0.
  - bit5: +subnormal.
  - bit6: +normal.
  - bit7: +inf.
  - bit8: signaling NaN (e=FF, f≠0, f[22]=0).
  - bit9: quiet NaN (e=FF, f[22]=1).
  - NaN classes ignore sign. FCLASS always sets nx=0.
- FCVT.S.W: rs1 is two's complement. Sign = rs1[31]; magnitude = |rs1| as 32-bit unsigned, so 0x80000000 gives magnitude 2^31.
- FCVT.S.WU: rs1 is unsigned; sign = 0.
- Conversion core, on magnitude m:
  - m = 0 → out = 0x00000000 (+0), nx = 0.
  - Otherwise, p = index of the leading one (0..31).
  - Biased exponent = 127 + p.
  - Normalize so the leading one is the hidden bit. Mantissa = the next 23 bits; remaining lower bits form guard (G) and sticky (S, OR of the rest).
  - nx = G|S.
  - Rounding increment:
    - RNE: G & (S | mantissa lsb).
    - RTZ: 0.
    - RDN: sign & (G|S).
    - RUP: ~sign & (G|S).
    - RMM: G.
  - Mantissa carry-out on increment → mantissa = 0, exponent +1. Maximum result is 2^32 (0x4F800000). Overflow, underflow and NaN are impossible.
- Unsupported operation with valid_in=1: out = 0, nx = 0, valid_out still asserted.
- rs2 has no effect on any output.

## Timing
- Inputs sampled at the rising edge where valid_in=1. The next cycle has valid_out=1 and out/nx = result.
- valid_in=0 at an edge: valid_out=0 next cycle; out and nx hold their previous values.
- Fully pipelined: a new operation is accepted every cycle, back-to-back, with no stall and no backpressure.
- Reset, at any edge where resetn=1, including mid-stream: valid_out=0, out=0x00000000, nx=0 next cycle. The in-flight operation is discarded.
- valid_in during a reset cycle is ignored.
- Combinational path: decode + leading-one detect + shift + round, all within one cycle before the output register.

## Test plan
- FCLASS sweep, each expecting nx=0:
  - 0xFF800000 → 0x001
  - 0xBF800000 → 0x002
  - 0x80000001 → 0x004
  - 0x80000000 → 0x008
  - 0x00000000 → 0x010
  - 0x00000001 → 0x020
  - 0x3F800000 → 0x040
  - 0x7F800000 → 0x080
  - 0x7F800001 → 0x100
  - 0x7FC00000 → 0x200
  - 0xFFC00000 → 0x200
- FCVT.S.W exact cases, each expecting nx=0:
  - 1 → 0x3F800000
  - −1 (0xFFFFFFFF) → 0xBF800000
  - 0 → 0x00000000
  - 0x80000000 → 0xCF000000
  - 0x7FFFFFFF (RNE) → 0x4F000000 with nx=1
- Rounding on 16777217 (0x01000001), op 4, each with nx=1:
  - RNE → 0x4B800000
  - RTZ → 0x4B800000
  - RUP → 0x4B800001
  - RMM → 0x4B800001
  - Negated input (0xFEFFFFFF), RDN → 0xCB800001
- FCVT.S.WU on 0xFFFFFFFF, each with nx=1:
  - RNE → 0x4F800000
  - RTZ → 0x4F7FFFFF
  - Plus 0x80000000 → 0x4F000000 with nx=0, proving no sign interpretation.
- Streaming and control sequence:
  - Back-to-back ops 8, 4, 5 on consecutive cycles → three consecutive valid_out cycles with matching results.
  - valid_in=0 gap → out holds its value.
  - Operation 9 → out=0, nx=0.
- Reset:
  - Assert resetn=1 one cycle after issuing an op → valid_out=0, out=0, nx=0 the next cycle; no stale result appears.
